// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: action encoding and
// elaboration-time parameter legality check.
package counter_pkg;

    localparam logic [2:0] ACT_HOLD = 3'd0;
    localparam logic [2:0] ACT_CLR  = 3'd1;
    localparam logic [2:0] ACT_LD   = 3'd2;
    localparam logic [2:0] ACT_INC  = 3'd3;
    localparam logic [2:0] ACT_DEC  = 3'd4;

    // True when WIDTH, MAX_VAL and RST_VAL describe a reachable counter range.
    function automatic bit params_ok(input int width,
                                     input longint unsigned max_val,
                                     input longint unsigned rst_val);
        longint unsigned lim;
        lim = (64'd1 << width) - 64'd1;
        return (width >= 2) && (width <= 32) && (max_val >= 64'd1) &&
               (max_val <= lim) && (rst_val <= max_val);
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count and wrap decode for the modulo-N up/down counter.
// Priority is clr > ld > en; exactly one action is chosen per edge.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] next_count,
    output logic             next_wrap
);

    localparam logic [WIDTH:0] MAX_EXT = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [2:0]     act;
    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;

    // One extra bit so +1 at all-ones and -1 at zero are visible, not lost.
    assign count_ext = {1'b0, count};
    assign ld_ext    = {1'b0, ld_val};
    assign inc_ext   = count_ext + ONE_EXT;
    assign dec_ext   = count_ext - ONE_EXT;

    always_comb begin
        act = ACT_HOLD;
        if (clr) begin
            act = ACT_CLR;
        end else if (ld) begin
            act = ACT_LD;
        end else if (en) begin
            act = up ? ACT_INC : ACT_DEC;
        end
    end

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        case (act)
            ACT_CLR: begin
                next_count = '0;
            end
            ACT_LD: begin
                next_count = (ld_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : ld_val;
            end
            ACT_INC: begin
                // count never exceeds MAX_VAL, so passing it means count was terminal
                if (inc_ext > MAX_EXT) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = inc_ext[WIDTH-1:0];
                end
            end
            ACT_DEC: begin
                // borrow out of the extended subtract means count was zero
                if (dec_ext[WIDTH]) begin
                    next_count = MAX_EXT[WIDTH-1:0];
                    next_wrap  = 1'b1;
                end else begin
                    next_count = dec_ext[WIDTH-1:0];
                end
            end
            default: begin
                next_count = count;
                next_wrap  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/counter_updown_mod.sv
// WIDTH-bit modulo-(MAX_VAL+1) up/down counter with clear, clamped load,
// combinational terminal-count flag and registered wrap pulse.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RST_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] counter,
    output logic             co,
    output logic             wrap
);

    if (!params_ok(WIDTH, MAX_VAL, RST_VAL)) begin : g_bad_params
        $error("counter_updown_mod: WIDTH/MAX_VAL/RST_VAL out of range");
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count      (counter),
        .up         (up),
        .en         (en),
        .clr        (clr),
        .ld         (ld),
        .ld_val     (ld_val),
        .next_count (next_count),
        .next_wrap  (next_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= RST_W;
            wrap    <= 1'b0;
        end else begin
            counter <= next_count;
            wrap    <= next_wrap;
        end
    end

    // Deliberately not gated by en: matches the legacy carry-out.
    assign co = up ? (counter == MAX_W) : (counter == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three parameterisations driven in lockstep and
// checked every cycle against a modular-arithmetic reference model.
module tb_counter_updown_mod;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       ld;
    logic [3:0] ld_val;

    logic [3:0] dut_cnt  [3];
    logic       dut_co   [3];
    logic       dut_wrap [3];

    int m_cnt  [3];
    bit m_wrap [3];
    int m_max  [3] = '{15, 9, 1};
    int m_rst  [3] = '{0, 2, 0};

    int tests_run;
    int tests_failed;

    counter_updown_mod #(.WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld), .ld_val(ld_val),
        .counter(dut_cnt[0]), .co(dut_co[0]), .wrap(dut_wrap[0])
    );

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld), .ld_val(ld_val),
        .counter(dut_cnt[1]), .co(dut_co[1]), .wrap(dut_wrap[1])
    );

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld), .ld_val(ld_val),
        .counter(dut_cnt[2]), .co(dut_co[2]), .wrap(dut_wrap[2])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = m_rst[i];
            m_wrap[i] = 1'b0;
        end
    endtask

    // Reference: counter lives in 0..max, advancing modulo (max+1).
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_cnt[i] = 0;
                m_wrap[i] = 1'b0;
            end else if (ld) begin
                m_cnt[i] = (int'(ld_val) > m_max[i]) ? m_max[i] : int'(ld_val);
                m_wrap[i] = 1'b0;
            end else if (en && up) begin
                m_wrap[i] = (m_cnt[i] == m_max[i]);
                m_cnt[i] = (m_cnt[i] + 1) % (m_max[i] + 1);
            end else if (en) begin
                m_wrap[i] = (m_cnt[i] == 0);
                m_cnt[i] = (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
            end else begin
                m_wrap[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string step);
        bit exp_co;
        for (int i = 0; i < 3; i++) begin
            exp_co = up ? (m_cnt[i] == m_max[i]) : (m_cnt[i] == 0);
            chk($sformatf("%s.cnt%0d", step, i), 32'(dut_cnt[i]), 32'(m_cnt[i]));
            chk($sformatf("%s.wrap%0d", step, i), 32'(dut_wrap[i]), 32'(m_wrap[i]));
            chk($sformatf("%s.co%0d", step, i), 32'(dut_co[i]), 32'(exp_co));
        end
    endtask

    // driver: inputs are set after negedge, captured at posedge, checked at negedge
    task automatic tick(input string step);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(step);
    endtask

    task automatic set_in(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u);
        clr = c; ld = l; ld_val = lv; en = e; up = u;
    endtask

    // Pulse rst between edges and confirm the asynchronous response.
    task automatic async_reset(input string step);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(step);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        set_in(0, 0, 4'd0, 0, 1);
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // 1: free-running up count through a full wrap
        set_in(0, 0, 4'd0, 1, 1);
        for (int k = 0; k < 17; k++) tick("up17");

        // 2: modulo-10 up and down wrap (start from a clear)
        set_in(1, 0, 4'd0, 1, 1);
        tick("clr2");
        set_in(0, 0, 4'd0, 1, 1);
        for (int k = 0; k < 10; k++) tick("mod_up");
        set_in(0, 0, 4'd0, 1, 0);
        #1;
        check_all("co_dir");
        tick("mod_down");
        tick("mod_down2");

        // 3: priority and clamped load
        set_in(0, 1, 4'd5, 0, 1);
        tick("ld5");
        set_in(1, 1, 4'd3, 1, 1);
        tick("prio");
        set_in(0, 1, 4'd12, 1, 1);
        tick("clamp");

        // 4: asynchronous reset mid-cycle
        set_in(0, 1, 4'd7, 0, 1);
        tick("ld7");
        async_reset("mid_rst");
        set_in(0, 0, 4'd0, 1, 1);
        tick("post_rst");

        // 5: back-to-back wraps on the modulo-2 instance
        set_in(1, 0, 4'd0, 0, 1);
        tick("clr5");
        set_in(0, 0, 4'd0, 1, 1);
        for (int k = 0; k < 4; k++) tick("b2b");

        // 6: hold with direction toggling
        set_in(0, 1, 4'd4, 0, 1);
        tick("ld4");
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 4'd0, 0, k[0]);
            tick("hold");
        end

        // random traffic with occasional clears, loads and async resets
        for (int k = 0; k < 300; k++) begin
            set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
